// File: rtl/pc_attack_engine.sv
// PC-side attacker for the 5x5 battleship board: picks an unattacked cell (LFSR first, linear scan
// as fallback), issues one write strobe per PC turn, and keeps the PC hit count / win flag.
module pc_attack_engine #(
    parameter int         N         = 5,
    parameter logic [7:0] LFSR_SEED = 8'hB4,
    parameter int         MAX_TRIES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pc_turn_State,
    input  logic [N-1:0][N-1:0][1:0]   tablero_jugador,
    input  logic [4:0]                 target_cells,
    output logic                       attack_valid,
    output logic [2:0]                 attack_i,
    output logic [2:0]                 attack_j,
    output logic [1:0]                 attack_val,
    output logic                       turn_done,
    output logic                       board_exhausted,
    output logic [4:0]                 pc_hits,
    output logic                       pc_wins
);

    typedef enum logic [2:0] {IDLE, PICK, CHECK, SCAN, COMMIT, DONE} state_t;

    localparam int          TW       = $clog2(MAX_TRIES + 1);
    localparam logic [3:0]  N4       = 4'(N);
    localparam logic [2:0]  LAST     = 3'(N - 1);
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
    localparam logic [1:0]  BARCO       = 2'b01;
    localparam logic [1:0]  ATACA_BARCO = 2'b10;
    localparam logic [1:0]  ATACA_AGUA  = 2'b11;

    state_t          state, state_next;
    logic [7:0]      lfsr;
    logic            turn_q;
    logic [TW-1:0]   tries;
    logic [2:0]      cand_i, cand_j;
    logic [2:0]      scan_i, scan_j;

    logic            start, pick_ok, out_of_tries, scan_last;
    logic [1:0]      cand_cell, scan_cell;

    assign start        = pc_turn_State && !turn_q;
    assign pick_ok      = ({1'b0, lfsr[2:0]} < N4) && ({1'b0, lfsr[5:3]} < N4);
    assign out_of_tries = (tries == TRY_LAST);
    assign scan_last    = (scan_i == LAST) && (scan_j == LAST);
    assign cand_cell    = tablero_jugador[cand_i][cand_j];
    assign scan_cell    = tablero_jugador[scan_i][scan_j];

    // The whole block runs on the falling edge of clk.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = PICK;
            PICK: begin
                if (pick_ok)           state_next = CHECK;
                else if (out_of_tries) state_next = SCAN;
            end
            CHECK: begin
                if (!cand_cell[1])     state_next = COMMIT;
                else if (out_of_tries) state_next = SCAN;
                else                   state_next = PICK;
            end
            SCAN: begin
                if (!scan_cell[1])     state_next = COMMIT;
                else if (scan_last)    state_next = DONE;
            end
            COMMIT: state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        attack_valid = (state == COMMIT);
        turn_done    = (state == DONE);
        pc_wins      = (target_cells != 5'd0) && (pc_hits == target_cells);
    end

    // Fibonacci LFSR, taps 8,6,5,4; free-running so the pick sequence depends on turn timing.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            lfsr   <= LFSR_SEED;
            turn_q <= 1'b0;
        end else begin
            lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            turn_q <= pc_turn_State;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            tries           <= '0;
            cand_i          <= '0;
            cand_j          <= '0;
            scan_i          <= '0;
            scan_j          <= '0;
            attack_i        <= '0;
            attack_j        <= '0;
            attack_val      <= '0;
            pc_hits         <= '0;
            board_exhausted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tries  <= '0;
                        scan_i <= '0;
                        scan_j <= '0;
                    end
                end
                PICK: begin
                    if (pick_ok) begin
                        cand_i <= lfsr[2:0];
                        cand_j <= lfsr[5:3];
                    end else begin
                        tries <= tries + TW'(1);
                    end
                end
                CHECK: begin
                    if (!cand_cell[1]) begin
                        attack_i   <= cand_i;
                        attack_j   <= cand_j;
                        attack_val <= (cand_cell == BARCO) ? ATACA_BARCO : ATACA_AGUA;
                    end else begin
                        tries <= tries + TW'(1);
                    end
                end
                SCAN: begin
                    if (!scan_cell[1]) begin
                        attack_i   <= scan_i;
                        attack_j   <= scan_j;
                        attack_val <= (scan_cell == BARCO) ? ATACA_BARCO : ATACA_AGUA;
                    end else if (scan_last) begin
                        board_exhausted <= 1'b1;
                    end else if (scan_j == LAST) begin
                        scan_j <= '0;
                        scan_i <= scan_i + 3'd1;
                    end else begin
                        scan_j <= scan_j + 3'd1;
                    end
                end
                COMMIT: begin
                    if (attack_val == ATACA_BARCO && pc_hits != 5'd31) begin
                        pc_hits <= pc_hits + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_attack_engine.sv
// Randomized bench for pc_attack_engine: a turn-level reference model predicts the attacked cell,
// strobe timing, exhaustion and the hit/win counters from the board and the LFSR sequence.
module tb_pc_attack_engine;

    localparam int         N         = 5;
    localparam int         MAX_TRIES = 16;
    localparam logic [7:0] SEED      = 8'hB4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     pc_turn = 1'b0;
    logic [N-1:0][N-1:0][1:0] board = '0;
    logic [4:0]               target = 5'd0;
    logic                     attack_valid, turn_done, board_exhausted, pc_wins;
    logic [2:0]               attack_i, attack_j;
    logic [1:0]               attack_val;
    logic [4:0]               pc_hits;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int hits_m    = 0;
    logic [7:0] lfsr_m;

    pc_attack_engine #(.N(N), .LFSR_SEED(SEED), .MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .rst(rst), .pc_turn_State(pc_turn), .tablero_jugador(board),
        .target_cells(target), .attack_valid(attack_valid), .attack_i(attack_i),
        .attack_j(attack_j), .attack_val(attack_val), .turn_done(turn_done),
        .board_exhausted(board_exhausted), .pc_hits(pc_hits), .pc_wins(pc_wins)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Random-number source of the game: same polynomial, same seed, steps on every falling edge.
    always @(negedge clk or negedge rst) begin
        if (!rst) lfsr_m <= SEED;
        else      lfsr_m <= step(lfsr_m);
    end

    // Walks the turn cycle by cycle from the first pick cycle (cycle 1). Returns the cycle of the
    // strobe (or of turn_done when the board is exhausted) and the chosen cell.
    function automatic void predict(input logic [7:0] l0, output int cyc, output int pi,
                                    output int pj, output bit exh);
        logic [7:0] l = l0;
        int tries = 0;
        int i, j;
        cyc = 0; pi = 0; pj = 0; exh = 1'b0;
        while (tries < MAX_TRIES) begin
            cyc++;
            i = int'(l[2:0]);
            j = int'(l[5:3]);
            l = step(l);
            if (i >= N || j >= N) begin
                tries++;
                continue;
            end
            cyc++;
            l = step(l);
            if (board[i][j][1]) begin
                tries++;
                continue;
            end
            pi = i; pj = j; cyc++;
            return;
        end
        for (int k = 0; k < N * N; k++) begin
            cyc++;
            if (!board[k / N][k % N][1]) begin
                pi = k / N; pj = k % N; cyc++;
                return;
            end
        end
        exh = 1'b1;
        cyc++;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        pc_turn = 1'b0;
        repeat (2) @(posedge clk);
        rst = 1'b1;
        hits_m = 0;
        repeat (2) @(posedge clk);
    endtask

    // One PC turn; board owner optionally applies the write. All checks are inline.
    task automatic run_turn(input bit drop_early, input bit apply_write, input string tag);
        int exp_cyc, exp_i, exp_j;
        bit exp_exh;
        int valid_cnt = 0, done_cnt = 0, valid_cyc = -1, done_cyc = -1;
        logic [2:0] got_i = '0, got_j = '0;
        logic [1:0] got_val = '0, exp_val, cell_before = '0;
        @(posedge clk);
        pc_turn = 1'b1;
        @(posedge clk);
        predict(lfsr_m, exp_cyc, exp_i, exp_j, exp_exh);
        exp_val = (board[exp_i][exp_j] == 2'b01) ? 2'b10 : 2'b11;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (attack_valid) begin
                valid_cnt++;
                valid_cyc = cyc;
                got_i = attack_i; got_j = attack_j; got_val = attack_val;
                cell_before = board[attack_i][attack_j];
            end
            if (turn_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 1 && drop_early) pc_turn = 1'b0;
            if (done_cyc > 0 && cyc >= done_cyc + 2) break;
            @(posedge clk);
        end
        total_cnt++;
        if (done_cnt !== 1) $display("FAIL %s turn_done count got %0d want 1", tag, done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc !== exp_cyc + (exp_exh ? 0 : 1))
            $display("FAIL %s turn_done cycle got %0d want %0d", tag, done_cyc, exp_cyc + (exp_exh ? 0 : 1));
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt !== (exp_exh ? 0 : 1))
            $display("FAIL %s attack_valid count got %0d want %0d", tag, valid_cnt, exp_exh ? 0 : 1);
        else pass_cnt++;
        if (!exp_exh) begin
            total_cnt++;
            if (valid_cyc !== exp_cyc) $display("FAIL %s strobe cycle got %0d want %0d", tag, valid_cyc, exp_cyc);
            else pass_cnt++;
            total_cnt++;
            if (got_i !== 3'(exp_i) || got_j !== 3'(exp_j))
                $display("FAIL %s cell got (%0d,%0d) want (%0d,%0d)", tag, got_i, got_j, exp_i, exp_j);
            else pass_cnt++;
            total_cnt++;
            if (got_val !== exp_val) $display("FAIL %s attack_val got %b want %b", tag, got_val, exp_val);
            else pass_cnt++;
            total_cnt++;
            if (cell_before[1] !== 1'b0) $display("FAIL %s attacked cell already hit, cell %b want 0x", tag, cell_before);
            else pass_cnt++;
            if (exp_val == 2'b10 && hits_m < 31) hits_m++;
            if (apply_write) board[got_i][got_j] = got_val;
        end else begin
            total_cnt++;
            if (board_exhausted !== 1'b1) $display("FAIL %s board_exhausted got %b want 1", tag, board_exhausted);
            else pass_cnt++;
        end
        total_cnt++;
        if (pc_hits !== 5'(hits_m)) $display("FAIL %s pc_hits got %0d want %0d", tag, pc_hits, hits_m);
        else pass_cnt++;
        total_cnt++;
        if (pc_wins !== (target != 0 && hits_m == int'(target)))
            $display("FAIL %s pc_wins got %b want %b", tag, pc_wins, (target != 0 && hits_m == int'(target)));
        else pass_cnt++;
        pc_turn = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        int exp_cyc, ei, ej, seen;
        bit eexh;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({attack_valid, attack_i, attack_j, attack_val, turn_done, board_exhausted, pc_hits, pc_wins} !== '0)
            $display("FAIL reset_initial outputs got %b want 0",
                     {attack_valid, attack_i, attack_j, attack_val, turn_done, board_exhausted, pc_hits, pc_wins});
        else pass_cnt++;
        do_reset();
        board = {N * N{2'b11}};
        @(posedge clk);
        pc_turn = 1'b1;
        @(posedge clk);
        predict(lfsr_m, exp_cyc, ei, ej, eexh);
        repeat (exp_cyc - 6) @(posedge clk);
        rst = 1'b0;
        pc_turn = 1'b0;
        #1;
        total_cnt++;
        if ({attack_valid, attack_i, attack_j, attack_val, turn_done, board_exhausted, pc_hits} !== '0)
            $display("FAIL reset_mid_scan outputs got %b want 0",
                     {attack_valid, attack_i, attack_j, attack_val, turn_done, board_exhausted, pc_hits});
        else pass_cnt++;
        repeat (2) @(posedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            if (attack_valid || turn_done || board_exhausted) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL reset_quiet activity cycles got %0d want 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_single_ship();
        do_reset();
        board = '0;
        board[2][3] = 2'b01;
        target = 5'd1;
        run_turn(1'b0, 1'b1, "single_ship");
    endtask

    task automatic test_scan();
        do_reset();
        board = {N * N{2'b11}};
        board[4][4] = 2'b01;
        target = 5'd1;
        run_turn(1'b1, 1'b1, "scan_last");
        total_cnt++;
        if (attack_i !== 3'd4 || attack_j !== 3'd4 || attack_val !== 2'b10 || pc_hits !== 5'd1)
            $display("FAIL scan_hold got (%0d,%0d,%b,%0d) want (4,4,10,1)", attack_i, attack_j, attack_val, pc_hits);
        else pass_cnt++;
    endtask

    task automatic test_exhausted();
        do_reset();
        for (int k = 0; k < N * N; k++) board[k / N][k % N] = (k % 3 == 0) ? 2'b10 : 2'b11;
        target = 5'd0;
        run_turn(1'b0, 1'b1, "exhausted");
    endtask

    task automatic test_win();
        int placed = 0;
        do_reset();
        board = '0;
        target = 5'd3;
        while (placed < 3) begin
            int r = $urandom_range(0, N * N - 1);
            if (board[r / N][r % N] == 2'b00) begin
                board[r / N][r % N] = 2'b01;
                placed++;
            end
        end
        for (int t = 0; t < N * N + 1; t++) run_turn(t[0], 1'b1, $sformatf("win_t%0d", t));
        total_cnt++;
        if (pc_hits !== 5'd3 || pc_wins !== 1'b1)
            $display("FAIL win_final got hits %0d wins %b want 3 1", pc_hits, pc_wins);
        else pass_cnt++;
    endtask

    task automatic test_random_boards();
        do_reset();
        target = 5'd0;
        for (int k = 0; k < N * N; k++) board[k / N][k % N] = 2'($urandom_range(0, 3));
        for (int t = 0; t < 8; t++) run_turn(1'b0, 1'b1, $sformatf("rand_t%0d", t));
    endtask

    task automatic test_saturate();
        do_reset();
        board = {N * N{2'b01}};
        target = 5'd0;
        for (int t = 0; t < 33; t++) run_turn(1'b1, 1'b0, $sformatf("sat_t%0d", t));
    endtask

    task automatic test_back_to_back();
        int dones;
        do_reset();
        board = '0;
        target = 5'd0;
        for (int pass = 0; pass < 2; pass++) begin
            dones = 0;
            @(posedge clk);
            pc_turn = 1'b1;
            repeat (50) begin
                @(posedge clk);
                if (turn_done) dones++;
            end
            pc_turn = 1'b0;
            repeat (2) @(posedge clk);
            total_cnt++;
            if (dones !== 1) $display("FAIL hold_level pass %0d turn_done count got %0d want 1", pass, dones);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_ship();
        test_scan();
        test_exhausted();
        test_win();
        test_random_boards();
        test_saturate();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pc_attack_engine.md
Name: pc_attack_engine

Overview:
Computer-side attacker for the battleship game: the mirror of the player-to-PC attack path. On each PC turn it reads the player's 5x5 board, chooses a not-yet-attacked cell via an internal LFSR (linear-scan fallback), and issues one write command (cell plus ATACA_BARCO/ATACA_AGUA) to the board owner. It also counts PC hits and flags a PC win. Sits between the game FSM (turn state) and the board storage block.

Parameters:
N, 5, board dimension (rows = cols = N, N <= 8)
LFSR_SEED, 8'hB4, non-zero reset value of the 8-bit LFSR
MAX_TRIES, 16, random picks rejected before switching to linear scan

Ports:
clk  in  1  system clock; all registers update on falling edge
rst  in  1  asynchronous, active-low reset
pc_turn_State  in  1  level, high while game FSM is in PC turn
tablero_jugador  in  2 x [N][N]  player board (00 AGUA, 01 BARCO, 10 ATACA_BARCO, 11 ATACA_AGUA)
target_cells  in  5  total ship cells placed by player
attack_valid  out  1  one-cycle write strobe to board owner
attack_i  out  3  row of attacked cell
attack_j  out  3  column of attacked cell
attack_val  out  2  value to write (10 or 11)
turn_done  out  1  one-cycle pulse, PC turn finished
board_exhausted  out  1  sticky, no unattacked cell existed
pc_hits  out  5  hits scored so far
pc_wins  out  1  level, pc_hits == target_cells and target_cells != 0

Behaviour:
- Reset (async, rst=0): all outputs 0, LFSR=LFSR_SEED, state IDLE, try counter 0, scan index 0, pc_turn_State edge register 0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every clock in every state except reset; never 0.
- States: IDLE, PICK, CHECK, SCAN, COMMIT, DONE.
- IDLE: on rising edge of pc_turn_State (registered previous value 0, current 1) -> PICK, tries=0. Holding the level high does not start a second turn.
- PICK: candidate i=lfsr[2:0], j=lfsr[5:3]; if i>=N or j>=N, tries++ and stay in PICK; else latch (i,j) -> CHECK.
- CHECK: cell=tablero_jugador[i][j]; if cell[1]==1 (already attacked), tries++ -> PICK; else -> COMMIT. When tries reaches MAX_TRIES in PICK or CHECK -> SCAN with index 0.
- SCAN: one cell per cycle, row-major (0,0)..(N-1,N-1); first cell with bit1==0 latched -> COMMIT. Index passes last cell with none found -> board_exhausted=1 -> DONE with no attack.
- COMMIT (1 cycle): attack_valid=1, attack_i/j=latched cell, attack_val=10 if cell==BARCO else 11; pc_hits +1 on BARCO (saturates at 31) -> DONE.
- DONE (1 cycle): turn_done=1 -> IDLE.
- attack_i/j/val hold last committed values between strobes; attack_valid and turn_done are 1 only for the single cycle described.
- Latency: random hit on first valid pick gives rising edge -> attack_valid in 3 cycles (PICK, CHECK, COMMIT), turn_done next cycle. Worst case bounded by 2*MAX_TRIES + N*N + 2 cycles.
- pc_turn_State dropping mid-turn: turn still completes (no abort). Reset mid-turn: immediate return to IDLE, no strobe.
- pc_wins combinational from pc_hits and target_cells; target_cells=0 gives pc_wins=0.
- Board input sampled only in CHECK/SCAN; block never writes board itself.

Test Plan:
- Reset: rst low mid-SCAN -> all outputs 0, state IDLE, no attack_valid afterwards until next pc_turn_State rise.
- Single ship at (2,3), rest water, seed default, one turn -> exactly one attack_valid, attack_val=10 iff (attack_i,attack_j)==(2,3), turn_done one cycle after, cell had bit1=0.
- 24 cells pre-marked 11, only (4,4)=01 unattacked, MAX_TRIES=16 -> SCAN finds (4,4), attack_val=10, pc_hits=1.
- All 25 cells attacked -> no attack_valid, board_exhausted=1, turn_done pulses once.
- target_cells=3, three ship cells, repeated turns with board owner applying writes -> pc_hits increments only on BARCO, pc_wins=1 exactly after third hit, never attacks same cell twice across 25 turns.
- pc_turn_State held high 50 cycles -> exactly one turn_done; toggling low/high -> second turn.
